// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, ALU
// operation codes, opcode constants and datapath operand/result selects.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_BAD  = 4'b1111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // One bundle for every state-decoded control output, so reset can clear them together.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// funct3/funct7_30 to ALU operation decode for register and immediate ALU ops.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_30,
    input  logic       is_rtype,
    output logic [3:0] alu_op,
    output logic       unsupported
);

    // funct7_30 only selects SUB for register ops; ADDI ignores it.
    always_comb begin
        alu_op      = ALU_ADD;
        unsupported = 1'b0;
        case (funct3)
            3'b000:  alu_op = (is_rtype && funct7_30) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            default: begin
                alu_op      = ALU_BAD;
                unsupported = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32 subset datapath.
// Define MULTICYCLE_CONTROL_INSTRET_EN to build the retired-instruction counter.
module multicycle_control
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_30,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_control,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [3:0] dec_op;
    logic       dec_bad;
    logic       is_rtype;

    assign is_rtype = (state == EXECR);

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7_30   (funct7_30),
        .is_rtype    (is_rtype),
        .alu_op      (dec_op),
        .unsupported (dec_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ctrl       = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req     = 1'b1;
                ctrl.adr_src     = 1'b0;
                ctrl.alu_src_a   = SRC_A_PC;
                ctrl.alu_src_b   = SRC_B_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.result_src  = RES_ALU;
                ctrl.ir_write    = mem_ready;
                ctrl.pc_write    = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                ctrl.alu_src_a   = SRC_A_OLDPC;
                ctrl.alu_src_b   = SRC_B_IMM;
                ctrl.alu_control = ALU_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    default:           next_state = TRAP;
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a   = SRC_A_RS1;
                ctrl.alu_src_b   = SRC_B_IMM;
                ctrl.alu_control = ALU_ADD;
                next_state       = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWRITE: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.adr_src = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEMDATA;
                next_state      = FETCH;
            end
            EXECR, EXECI: begin
                ctrl.alu_src_a   = SRC_A_RS1;
                ctrl.alu_src_b   = (state == EXECR) ? SRC_B_RS2 : SRC_B_IMM;
                ctrl.alu_control = dec_op;
                next_state       = dec_bad ? TRAP : ALUWB;
            end
            ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                next_state      = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a   = SRC_A_RS1;
                ctrl.alu_src_b   = SRC_B_RS2;
                ctrl.alu_control = ALU_SUB;
                case (funct3)
                    F3_BEQ, F3_BNE: begin
                        next_state = FETCH;
                        // BNE inverts the zero test; the target was latched in DECODE.
                        if (zero ^ funct3[0]) begin
                            ctrl.pc_write   = 1'b1;
                            ctrl.result_src = RES_ALUOUT;
                        end
                    end
                    default: next_state = TRAP;
                endcase
            end
            JAL: begin
                ctrl.pc_write    = 1'b1;
                ctrl.result_src  = RES_ALUOUT;
                ctrl.alu_src_a   = SRC_A_OLDPC;
                ctrl.alu_src_b   = SRC_B_FOUR;
                ctrl.alu_control = ALU_ADD;
                next_state       = ALUWB;
            end
            TRAP: begin
                ctrl.illegal = 1'b1;
                next_state   = TRAP;
            end
            default: next_state = FETCH;
        endcase
    end

    // Reset clears every output combinationally so an in-flight access is dropped at once.
    assign ctrl_out    = rst_n ? ctrl : '0;
    assign mem_req     = ctrl_out.mem_req;
    assign mem_we      = ctrl_out.mem_we;
    assign adr_src     = ctrl_out.adr_src;
    assign ir_write    = ctrl_out.ir_write;
    assign pc_write    = ctrl_out.pc_write;
    assign reg_write   = ctrl_out.reg_write;
    assign alu_src_a   = ctrl_out.alu_src_a;
    assign alu_src_b   = ctrl_out.alu_src_b;
    assign result_src  = ctrl_out.result_src;
    assign alu_control = ctrl_out.alu_control;
    assign illegal     = ctrl_out.illegal;

`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (next_state == FETCH) &&
                    ((state == MEMWB) || (state == MEMWRITE) ||
                     (state == ALUWB) || (state == BRANCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of per-cycle vectors plus
// hand-written wait-state, trap and reset sequences, checked via a scoreboard.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_30;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic        illegal;
    logic [31:0] instret;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_30   (funct7_30),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output layout: mem_req,mem_we,adr_src,ir_write,pc_write,reg_write,a[2],b[2],rs[2],alu[4],illegal
    localparam logic [16:0] M_CTRL = 17'h1F801;
    localparam logic [16:0] M_DP   = 17'h0079E;
    localparam logic [16:0] M_RS   = 17'h00060;
    localparam logic [16:0] M_ALL  = 17'h1FFFF;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_30;
        logic        zero;
        logic        mem_ready;
        logic [16:0] exp;
        logic [16:0] mask;
        string       name;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        logic [16:0] mask;
        string       name;
    } sb_t;

    vec_t vectors[$];
    sb_t  sb_q[$];
    int   checks;
    int   errors;

    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       cur_zero;

    function automatic logic [16:0] pk(input logic mreq, input logic we, input logic adr,
                                       input logic ir, input logic pc, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [3:0] alu,
                                       input logic ill);
        return {mreq, we, adr, ir, pc, rw, a, b, rs, alu, ill};
    endfunction

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        cur_opc  = o;
        cur_f3   = f3;
        cur_f7   = f7;
        cur_zero = z;
    endtask

    task automatic add(input logic mr, input logic [16:0] e, input logic [16:0] m, input string n);
        vec_t v;
        v.opcode    = cur_opc;
        v.funct3    = cur_f3;
        v.funct7_30 = cur_f7;
        v.zero      = cur_zero;
        v.mem_ready = mr;
        v.exp       = e;
        v.mask      = m;
        v.name      = n;
        vectors.push_back(v);
    endtask

    task automatic add_fetch();
        add(1'b1, pk(1,0,0,1,1,0, 2'b00,2'b10,2'b10, 4'b0010, 0), M_ALL, "fetch");
    endtask

    task automatic add_fetch_stall();
        add(1'b0, pk(1,0,0,0,0,0, 2'b00,2'b10,2'b10, 4'b0010, 0), M_ALL, "fetch_stall");
    endtask

    task automatic add_decode();
        add(1'b1, pk(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 4'b0010, 0), M_CTRL | M_DP, "decode");
    endtask

    task automatic add_exec(input logic [1:0] b, input logic [3:0] alu, input string n);
        add(1'b1, pk(0,0,0,0,0,0, 2'b10,b,2'b00, alu, 0), M_CTRL | M_DP, n);
    endtask

    task automatic add_aluwb();
        add(1'b1, pk(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 4'b0000, 0), M_CTRL | M_RS, "aluwb");
    endtask

    task automatic add_memadr();
        add(1'b1, pk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 4'b0010, 0), M_CTRL | M_DP, "memadr");
    endtask

    task automatic add_branch(input logic taken, input string n);
        add(1'b1, pk(0,0,0,0,taken,0, 2'b10,2'b00,2'b00, 4'b0110, 0),
            taken ? (M_CTRL | M_DP | M_RS) : (M_CTRL | M_DP), n);
    endtask

    task automatic add_trap(input logic mr);
        add(mr, pk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 4'b0000, 1), M_CTRL, "trap");
    endtask

    task automatic checkOutput();
        sb_t         s;
        logic [16:0] act;
        act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_control, illegal};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got %h with no expected entry", act);
        end else begin
            s = sb_q.pop_front();
            if (((act ^ s.exp) & s.mask) != 17'h0) begin
                errors++;
                $display("[TB] FAIL %s: got %h expected %h (mask %h) at %0t",
                         s.name, act, s.exp, s.mask, $time);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        opcode    = v.opcode;
        funct3    = v.funct3;
        funct7_30 = v.funct7_30;
        zero      = v.zero;
        mem_ready = v.mem_ready;
        sb_q.push_back('{v.exp, v.mask, v.name});
        @(negedge clk);
        checkOutput();
    endtask

    task automatic run_queued();
        foreach (vectors[i]) applyStimulus(vectors[i]);
        vectors.delete();
    endtask

    task automatic check_instret(input logic [31:0] e, input string n);
        checks++;
        if (instret !== e) begin
            errors++;
            $display("[TB] FAIL %s: instret got %h expected %h", n, instret, e);
        end
    endtask

    // Asserts reset immediately, checks all outputs are cleared, then releases at a negedge.
    task automatic doReset(input string n);
        rst_n = 1'b0;
        #1;
        sb_q.push_back('{17'h0, M_ALL, n});
        checkOutput();
        check_instret(32'h0, {n, "_instret"});
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        opcode    = '0;
        funct3    = '0;
        funct7_30 = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #2;
        doReset("reset_state");

        // Table: straight-line instructions with mem_ready high
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b00, 4'b0110, "execr_sub"); add_aluwb();
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b01, 4'b0010, "execi_addi_f7"); add_aluwb();
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b00, 4'b0010, "execr_add"); add_aluwb();
        set_instr(7'b0110011, 3'b100, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b00, 4'b1100, "execr_xor"); add_aluwb();
        set_instr(7'b0010011, 3'b011, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b01, 4'b0111, "execi_sltu"); add_aluwb();
        set_instr(7'b0110011, 3'b110, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b00, 4'b0001, "execr_or"); add_aluwb();
        set_instr(7'b0010011, 3'b111, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b01, 4'b0000, "execi_and"); add_aluwb();
        set_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b00, 4'b0100, "execr_slt"); add_aluwb();
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_memadr();
        add(1'b1, pk(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 4'b0000, 0), M_CTRL, "memwrite");
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        add_fetch(); add_decode(); add_branch(1'b1, "beq_z1_taken");
        set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
        add_fetch(); add_decode(); add_branch(1'b0, "bne_z1_not_taken");
        set_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_branch(1'b1, "bne_z0_taken");
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_branch(1'b0, "beq_z0_not_taken");
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        add_fetch(); add_decode();
        add(1'b1, pk(0,0,0,0,1,0, 2'b01,2'b10,2'b00, 4'b0010, 0), M_ALL, "jal");
        add_aluwb();
        add_fetch_stall();
        for (int i = 0; i < vectors.size(); i++) applyStimulus(vectors[i]);
        vectors.delete();
`ifndef MULTICYCLE_CONTROL_INSTRET_EN
        check_instret(32'h0, "instret_disabled");
`endif

        // Load with three wait cycles in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_memadr();
        for (int i = 0; i < 3; i++)
            add(1'b0, pk(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 4'b0000, 0), M_CTRL, "memread_wait");
        add(1'b1, pk(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 4'b0000, 0), M_CTRL, "memread_done");
        add(1'b1, pk(0,0,0,0,0,1, 2'b00,2'b00,2'b01, 4'b0000, 0), M_CTRL | M_RS, "memwb");
        add_fetch_stall();
        run_queued();

`ifdef MULTICYCLE_CONTROL_INSTRET_EN
        dut.instret_q = 32'hFFFF_FFFF;
        set_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_exec(2'b01, 4'b0010, "execi_addi"); add_aluwb();
        add_fetch_stall();
        run_queued();
        check_instret(32'h0, "instret_wrap");
`endif

        // Unsupported funct3 in EXECR traps
        set_instr(7'b0110011, 3'b001, 1'b0, 1'b0);
        add_fetch(); add_decode();
        add(1'b1, pk(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 4'b1111, 0), (M_CTRL | M_DP) & ~17'h1, "execr_bad_f3");
        add_trap(1'b1);
        run_queued();
        doReset("reset_after_bad_f3");

        // Illegal opcode: sticky TRAP for 10 cycles, then reset restarts in FETCH
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        add_fetch(); add_decode();
        for (int i = 0; i < 10; i++) add_trap(i[0]);
        run_queued();
        doReset("reset_from_trap");
        add_fetch_stall();
        run_queued();

        // Unsupported branch funct3 traps
        set_instr(7'b1100011, 3'b100, 1'b0, 1'b1);
        add_fetch(); add_decode(); add_branch(1'b0, "branch_bad_f3"); add_trap(1'b1);
        run_queued();
        doReset("reset_after_bad_branch");

        // Reset pulsed mid-MEMWRITE drops mem_req at once
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        add_fetch(); add_decode(); add_memadr();
        add(1'b0, pk(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 4'b0000, 0), M_CTRL, "memwrite_wait");
        run_queued();
        @(posedge clk);
        #2;
        doReset("reset_mid_memwrite");
        add_fetch_stall();
        add_fetch(); add_decode();
        run_queued();

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 7, instr[6:0] from the instruction register.
REQ-004 SHALL have port funct3, input, 3, instr[14:12].
REQ-005 SHALL have port funct7_30, input, 1, instr[30].
REQ-006 SHALL have port zero, input, 1, ALU zero flag for the current cycle.
REQ-007 SHALL have port mem_ready, input, 1, memory completion strobe.
REQ-008 SHALL have port mem_req, output, 1, memory access request.
REQ-009 SHALL have port mem_we, output, 1, write qualifier for mem_req.
REQ-010 SHALL have port adr_src, output, 1, memory address select: 0 = PC, 1 = ALU result register.
REQ-011 SHALL have ports ir_write, pc_write, reg_write, each output, 1, register load enables.
REQ-012 SHALL have ports alu_src_a and alu_src_b, each output, 2, ALU operand selects.
- alu_src_a: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 SHALL have port result_src, output, 2, result select: 00 = ALU result register, 01 = memory data, 10 = live ALU output.
REQ-014 SHALL have port alu_control, output, 4, ALU operation select.
REQ-015 SHALL have port illegal, output, 1, sticky illegal-instruction flag.
REQ-016 SHALL have port instret, output, 32, retired-instruction count.

Function
REQ-017 SHALL be a Moore FSM. All outputs SHALL be decoded from the state only, except the branch pc_write.
REQ-018 SHALL use these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
REQ-019 SHALL behave in FETCH as follows:
- Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=ADD, result_src=10.
- When mem_ready=1: ir_write=1 and pc_write=1 in that cycle, then go to DECODE.
- Otherwise stay in FETCH with no register writes.
REQ-020 SHALL, in DECODE, compute the branch target (alu_src_a=01, alu_src_b=01, ADD) and go to the next state by opcode:
- 0000011 or 0100011: MEMADR.
- 0110011: EXECR.
- 0010011: EXECI.
- 1100011: BRANCH.
- 1101111: JAL.
- Any other opcode: TRAP.
REQ-021 SHALL compute rs1+imm in MEMADR, then go to MEMREAD for a load (opcode[5]=0) or MEMWRITE for a store (opcode[5]=1).
REQ-022 SHALL, in MEMREAD and MEMWRITE, drive mem_req=1 and adr_src=1; MEMWRITE additionally drives mem_we=1.
- Each state SHALL hold until mem_ready=1.
- On mem_ready=1, MEMREAD goes to MEMWB and MEMWRITE goes to FETCH.
REQ-023 SHALL, in MEMWB, drive reg_write=1 and result_src=01, then go to FETCH.
REQ-024 SHALL, in EXECR (alu_src_b=00) and EXECI (alu_src_b=01), drive alu_src_a=10 and the decoded alu_control, then go to ALUWB.
REQ-025 SHALL, in ALUWB, drive reg_write=1 and result_src=00, then go to FETCH.
REQ-026 SHALL decode alu_control as follows:
- EXECR: ADD 0010 or SUB 0110 (funct3=000, selected by funct7_30).
- EXECR and EXECI: AND 0000, OR 0001, XOR 1100, SLT 0100, SLTU 0111.
- EXECI with funct3=000: always ADD, regardless of funct7_30.
- Unsupported funct3: 1111, which SHALL also set illegal and go to TRAP instead of ALUWB.
REQ-027 SHALL, in BRANCH, compare rs1 and rs2 with SUB and go to FETCH.
- pc_write=1 and result_src=00 when (funct3=000 and zero=1) or (funct3=001 and zero=0).
- Any other funct3 SHALL go to TRAP.
REQ-028 SHALL, in JAL, drive pc_write=1 and result_src=00, and compute old PC+4 (alu_src_a=01, alu_src_b=10), then go to ALUWB.
REQ-029 SHALL, in TRAP, hold illegal=1 with all enables 0 until reset.
REQ-030 SHALL ignore mem_ready while mem_req=0.
REQ-031 SHALL take these minimum cycles per instruction with mem_ready tied high: R/I/JAL 4, load 5, store 4, branch 3.
- Each cycle of mem_ready low SHALL add exactly 1 cycle.

Reset
REQ-032 SHALL, while rst_n=0, force the state to FETCH, illegal=0, instret=0, and every output to 0, including mem_req.
REQ-033 SHALL assert mem_req in the first cycle after rst_n rises.
REQ-034 SHALL, if reset asserts mid-access, drop mem_req immediately and discard the access.

Configuration
REQ-035 SHALL implement MULTICYCLE_CONTROL_INSTRET_EN:
- When defined: instret SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH, wrapping from FFFFFFFF to 0.
- When undefined: instret SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-036 SHALL take the following from shared package rv_ctrl_pkg:
- The state enum.
- The ALU operation codes.
- The opcode constants.
- The operand-select encodings.
REQ-037 SHALL place the combinational funct3/funct7_30-to-alu_control decode in sub-module alu_decoder.

Verification
REQ-038 SHALL cover: with mem_ready=1, issue R-type opcode=0110011, funct3=000, funct7_30=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_control=0110 in EXECR; reg_write=1 in cycle 4.
REQ-039 SHALL cover: load opcode=0000011 with mem_ready low for 3 cycles in MEMREAD -> mem_req held high and adr_src=1 for 4 cycles; MEMWB reg_write=1 with result_src=01.
REQ-040 SHALL cover: BEQ with zero=1 -> pc_write=1 in BRANCH; BNE with zero=1 -> pc_write=0; both return to FETCH in cycle 4.
REQ-041 SHALL cover: opcode=1111111 -> TRAP after DECODE; illegal=1 persists for 10 cycles; rst_n low clears illegal and restarts in FETCH.
REQ-042 SHALL cover: ADDI opcode=0010011, funct3=000, funct7_30=1 -> alu_control=0010.
REQ-043 SHALL cover, with MULTICYCLE_CONTROL_INSTRET_EN: instret preset to FFFFFFFF plus one retire -> instret=0.
REQ-044 SHALL cover: rst_n pulsed low during MEMWRITE -> mem_req=0 immediately.
